// File: rtl/sl_transmitter_if.sv
// Word-side handshake and two-wire link signals of the SL transmitter.
// The transmitter uses the slave view; a word source / link observer uses master.
interface sl_transmitter_if;
    logic [1:0]  mode;
    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic        sl0;
    logic        sl1;
    logic        sent;

    modport master (output mode, data, valid, input ready, sl0, sl1, sent);
    modport slave  (input mode, data, valid, output ready, sl0, sl1, sent);
endinterface

// File: rtl/sl_transmitter.sv
// SL link transmitter: serializes an 8/16/24/32-bit word MSB first, then an
// odd-parity symbol and a both-low stop symbol, onto the sl0/sl1 pulse lines.
module sl_transmitter #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    sl_transmitter_if.slave bus
);

    localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [TW-1:0] T_PULSE = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] T_GAP   = TW'(GAP_CYCLES - 1);
    // The IDLE cycle that raises ready/sent doubles as the final stop-gap
    // cycle, so back-to-back words are separated by exactly GAP_CYCLES.
    localparam logic [TW-1:0] T_SGAP  = TW'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

    typedef enum logic [2:0] {
        IDLE,
        BIT_LOW,
        BIT_GAP,
        STOP_LOW,
        STOP_GAP
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [32:0]   shift_q, shift_d;
    logic          sl0_q, sl0_d;
    logic          sl1_q, sl1_d;
    logic          ready_q, ready_d;
    logic          sent_q, sent_d;

    logic [32:0]   load_vec;
    logic [5:0]    load_cnt;

    // Word left-aligned in the shifter with its parity bit directly below it.
    always_comb begin
        load_vec = '0;
        load_cnt = '0;
        case (bus.mode)
            2'b00: begin
                load_vec = {bus.data[7:0], ~^bus.data[7:0], 24'b0};
                load_cnt = 6'd9;
            end
            2'b01: begin
                load_vec = {bus.data[15:0], ~^bus.data[15:0], 16'b0};
                load_cnt = 6'd17;
            end
            2'b10: begin
                load_vec = {bus.data[23:0], ~^bus.data[23:0], 8'b0};
                load_cnt = 6'd25;
            end
            default: begin
                load_vec = {bus.data[31:0], ~^bus.data[31:0]};
                load_cnt = 6'd33;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (bus.valid && ready_q) begin
                    state_d = BIT_LOW;
                    tmr_d   = T_PULSE;
                    cnt_d   = load_cnt;
                    shift_d = load_vec;
                end
            end
            BIT_LOW: begin
                if (tmr_q == '0) begin
                    state_d = BIT_GAP;
                    tmr_d   = T_GAP;
                    cnt_d   = cnt_q - 6'd1;
                    shift_d = {shift_q[31:0], 1'b0};
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            BIT_GAP: begin
                if (tmr_q == '0) begin
                    state_d = (cnt_q != '0) ? BIT_LOW : STOP_LOW;
                    tmr_d   = T_PULSE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            STOP_LOW: begin
                if (tmr_q == '0) begin
                    state_d = (GAP_CYCLES > 1) ? STOP_GAP : IDLE;
                    tmr_d   = T_SGAP;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            STOP_GAP: begin
                if (tmr_q == '0) begin
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register cleanly.
    always_comb begin
        sl0_d   = !((state_d == STOP_LOW) || (state_d == BIT_LOW && !shift_d[32]));
        sl1_d   = !((state_d == STOP_LOW) || (state_d == BIT_LOW &&  shift_d[32]));
        ready_d = (state_d == IDLE);
        sent_d  = (state_d == IDLE) && (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            sl0_q   <= 1'b1;
            sl1_q   <= 1'b1;
            ready_q <= 1'b1;
            sent_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            sl0_q   <= sl0_d;
            sl1_q   <= sl1_d;
            ready_q <= ready_d;
            sent_q  <= sent_d;
        end
    end

    assign bus.sl0   = sl0_q;
    assign bus.sl1   = sl1_q;
    assign bus.ready = ready_q;
    assign bus.sent  = sent_q;

endmodule
